// File: rtl/io_bridge.sv
// Byte-bus bridge between the core and RAM / memory-mapped I/O at 0x30000+.
// Holds the UART TX FIFO, RX pop, free-running cycle counter and halt flag.
module io_bridge #(
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt_out,
  output logic        tx_overflow
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C  = PW'(TX_DEPTH);
  localparam logic [PW-1:0] THRESH_C = PW'(TX_DEPTH - FULL_MARGIN);

  logic          is_io;
  logic [15:0]   io_off;
  logic          acc_rd;
  logic          acc_wr;
  logic          unused_addr;

  logic          sel_ram_q, sel_ram_d;
  logic [7:0]    io_byte_q, io_byte_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   snap_q, snap_d;
  logic          halt_q, halt_d;
  logic          ovf_q, ovf_d;
  logic          full_q, full_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [TX_DEPTH];
  logic [7:0]    mem_d [TX_DEPTH];

  logic          fifo_full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic [7:0]    push_data;

  assign unused_addr = ^cpu_a[31:18];

  assign is_io  = (cpu_a[17:16] == 2'b11);
  assign io_off = cpu_a[15:0];
  assign acc_rd = rdy_in & ~cpu_wr;
  assign acc_wr = rdy_in & cpu_wr;

  assign ram_a   = cpu_a[16:0];
  assign ram_din = cpu_dout;
  assign ram_wr  = acc_wr & ~is_io;

  assign rx_pop  = acc_rd & is_io & (io_off == 16'h0000) & rx_valid;
  assign cpu_din = sel_ram_q ? ram_dout : io_byte_q;

  assign tx_valid  = (wr_ptr_q != rd_ptr_q);
  assign fifo_full = ((wr_ptr_q - rd_ptr_q) == DEPTH_C);
  assign tx_data   = mem_q[rd_ptr_q[AW-1:0]];

  assign pop       = tx_valid & tx_ready;
  assign push_req  = acc_wr & is_io &
                     (((io_off == 16'h0000) && (cpu_dout != 8'h00)) || (io_off == 16'h0004));
  assign push_data = (io_off == 16'h0004) ? 8'h00 : cpu_dout;
  // A push on a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok   = push_req & (~fifo_full | pop);

  always_comb begin
    sel_ram_d = sel_ram_q;
    io_byte_d = io_byte_q;
    snap_d    = snap_q;
    if (acc_rd) begin
      sel_ram_d = ~is_io;
      if (is_io) begin
        case (io_off)
          16'h0000: io_byte_d = rx_valid ? rx_data : 8'h00;
          16'h0004: begin
            io_byte_d = cnt_q[7:0];
            snap_d    = cnt_q;
          end
          16'h0005: io_byte_d = snap_q[15:8];
          16'h0006: io_byte_d = snap_q[23:16];
          16'h0007: io_byte_d = snap_q[31:24];
          default:  io_byte_d = 8'h00;
        endcase
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q + 32'd1;
    halt_d   = halt_q | (acc_wr & is_io & (io_off == 16'h0004));
    ovf_d    = ovf_q | (push_req & fifo_full & ~pop);
    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    full_d   = ((wr_ptr_d - rd_ptr_d) >= THRESH_C);
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_ram_q <= 1'b0;
      io_byte_q <= 8'h00;
      cnt_q     <= 32'h0;
      snap_q    <= 32'h0;
      halt_q    <= 1'b0;
      ovf_q     <= 1'b0;
      full_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < TX_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      sel_ram_q <= sel_ram_d;
      io_byte_q <= io_byte_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      halt_q    <= halt_d;
      ovf_q     <= ovf_d;
      full_q    <= full_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
    end
  end

  assign halt_out       = halt_q;
  assign tx_overflow    = ovf_q;
  assign io_buffer_full = full_q;

endmodule
